lo_iq_demod: RTL and testbench



---
 rtl/lo_iq_demod.sv | 151 +++++++++++++++
 tb/tb_lo_iq_demod.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lo_iq_demod.sv
// lo_iq_demod: integrate-and-dump quadrature demodulator.
// Multiplies a 1-bit (+/-1) sample stream by the 1-bit sin/cos LO pair and
// accumulates both products over 2^WIN_LOG2 enabled samples. At the end of
// each window the signed I/Q sums and an |I|+|Q| magnitude estimate are
// registered onto a valid/ready output port.
//
// Ports:
//   clk_ext    - system clock, rising edge
//   rst_ext    - synchronous active-high reset
//   en         - sample strobe; din/sin_lo/cos_lo consumed only when 1
//   din        - sample bit (1 = +1, 0 = -1)
//   sin_lo     - in-phase LO bit
//   cos_lo     - quadrature LO bit
//   out_ready  - consumer accepts the current result
//   clr_ovf    - clears the sticky overrun flag
//   i_out      - signed I sum of the last completed window
//   q_out      - signed Q sum of the last completed window
//   mag_out    - unsigned |i_out| + |q_out|
//   out_valid  - result held and awaiting acceptance
//   ovf        - sticky: a window completed while a result was unaccepted
module lo_iq_demod #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                    clk_ext,
  input  logic                    rst_ext,
  input  logic                    en,
  input  logic                    din,
  input  logic                    sin_lo,
  input  logic                    cos_lo,
  input  logic                    out_ready,
  input  logic                    clr_ovf,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic        [ACC_W:0]   mag_out,
  output logic                    out_valid,
  output logic                    ovf
);

  // Accumulators hold [-2^WIN_LOG2, +2^WIN_LOG2] without wrapping.
  localparam int unsigned AW = WIN_LOG2 + 2;
  localparam int unsigned MW = ACC_W + 1;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  // Elaboration-time parameter legality checks.
  if (WIN_LOG2 < 2 || WIN_LOG2 > 14) begin : g_bad_win
    $error("lo_iq_demod: WIN_LOG2 must be in 2..14");
  end
  if (ACC_W < WIN_LOG2 + 2) begin : g_bad_accw
    $error("lo_iq_demod: ACC_W must be >= WIN_LOG2+2");
  end

  logic signed [AW-1:0]    r_acc_i;
  logic signed [AW-1:0]    r_acc_q;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic signed [ACC_W-1:0] r_i;
  logic signed [ACC_W-1:0] r_q;
  logic [MW-1:0]           r_mag;
  logic                    r_valid;
  logic                    r_ovf;

  logic                    w_match_i;
  logic                    w_match_q;
  logic signed [AW-1:0]    w_p_i;
  logic signed [AW-1:0]    w_p_q;
  logic signed [AW-1:0]    w_sum_i;
  logic signed [AW-1:0]    w_sum_q;
  logic signed [ACC_W-1:0] w_new_i;
  logic signed [ACC_W-1:0] w_new_q;
  logic signed [MW-1:0]    w_ext_i;
  logic signed [MW-1:0]    w_ext_q;
  logic [MW-1:0]           w_abs_i;
  logic [MW-1:0]           w_abs_q;
  logic [MW-1:0]           w_mag;
  logic                    w_dump;
  logic                    w_accept;
  logic                    w_overrun;

  // Products as +1 (0..01) on match, -1 (all ones) on mismatch.
  assign w_match_i = (din == sin_lo);
  assign w_match_q = (din == cos_lo);
  assign w_p_i     = {{(AW-1){~w_match_i}}, 1'b1};
  assign w_p_q     = {{(AW-1){~w_match_q}}, 1'b1};
  assign w_sum_i   = r_acc_i + w_p_i;
  assign w_sum_q   = r_acc_q + w_p_q;

  // Sign-extend the window sums to the output width.
  assign w_new_i   = ACC_W'(w_sum_i);
  assign w_new_q   = ACC_W'(w_sum_q);

  // Magnitude is formed one bit wider so the negation cannot overflow.
  assign w_ext_i   = MW'(w_new_i);
  assign w_ext_q   = MW'(w_new_q);
  assign w_abs_i   = w_ext_i[MW-1] ? MW'(-w_ext_i) : MW'(w_ext_i);
  assign w_abs_q   = w_ext_q[MW-1] ? MW'(-w_ext_q) : MW'(w_ext_q);
  assign w_mag     = w_abs_i + w_abs_q;

  assign w_dump    = en && (r_cnt == CNT_LAST);
  assign w_accept  = r_valid && out_ready;
  assign w_overrun = w_dump && r_valid && !out_ready;

  // Accumulation, dump, handshake and overrun state.
  always_ff @(posedge clk_ext) begin
    if (rst_ext) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
      r_i     <= '0;
      r_q     <= '0;
      r_mag   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (en) begin
        if (w_dump) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
          r_cnt   <= r_cnt + WIN_LOG2'(1);
        end
      end

      // A dump always loads, even when it coincides with acceptance.
      if (w_dump) begin
        r_i     <= w_new_i;
        r_q     <= w_new_q;
        r_mag   <= w_mag;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      // Set has priority over clear.
      if (w_overrun) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign i_out     = r_i;
  assign q_out     = r_q;
  assign mag_out   = r_mag;
  assign out_valid = r_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_lo_iq_demod.sv
// Directed testbench for lo_iq_demod: default instance (WIN_LOG2=8, ACC_W=16)
// plus a width-corner instance (WIN_LOG2=14, ACC_W=16).
module tb_lo_iq_demod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic sin_lo = 1'b0;
  logic cos_lo = 1'b0;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  logic en14 = 1'b0;
  logic rdy14 = 1'b0;

  logic signed [15:0] i_o, q_o, i14, q14;
  logic [16:0] mag, mag14;
  logic vld, ovf, vld14, ovf14;

  int n_vec = 0;
  int n_err = 0;

  lo_iq_demod #(.WIN_LOG2(8), .ACC_W(16)) u_dut (
    .clk_ext(clk), .rst_ext(rst), .en(en), .din(din), .sin_lo(sin_lo),
    .cos_lo(cos_lo), .out_ready(rdy), .clr_ovf(clr), .i_out(i_o),
    .q_out(q_o), .mag_out(mag), .out_valid(vld), .ovf(ovf)
  );

  lo_iq_demod #(.WIN_LOG2(14), .ACC_W(16)) u_dut14 (
    .clk_ext(clk), .rst_ext(rst), .en(en14), .din(din), .sin_lo(sin_lo),
    .cos_lo(cos_lo), .out_ready(rdy14), .clr_ovf(clr), .i_out(i14),
    .q_out(q14), .mag_out(mag14), .out_valid(vld14), .ovf(ovf14)
  );

  // LO model: period-64 square waves, cos leads sin by a quarter period.
  function automatic logic sin_at(input int k);
    return (k % 64) < 32;
  endfunction

  function automatic logic cos_at(input int k);
    return ((k + 16) % 64) < 32;
  endfunction

  // One enabled sample; outputs are observed on the following negedge.
  task automatic feed(input logic d, input logic s, input logic c);
    en = 1'b1; din = d; sin_lo = s; cos_lo = c;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic accept();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; din = 1'b1; sin_lo = 1'b1; cos_lo = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    n_vec++; if (i_o !== 16'h0000) begin n_err++; $display("FAIL rst_i: got %h expected %h", i_o, 16'h0000); end
    n_vec++; if (q_o !== 16'h0000) begin n_err++; $display("FAIL rst_q: got %h expected %h", q_o, 16'h0000); end
    n_vec++; if (mag !== 17'h00000) begin n_err++; $display("FAIL rst_mag: got %h expected %h", mag, 17'h00000); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b expected %b", vld, 1'b0); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected %b", ovf, 1'b0); end
    n_vec++; if (vld14 !== 1'b0) begin n_err++; $display("FAIL rst_vld14: got %b expected %b", vld14, 1'b0); end
  endtask

  task automatic test_same_phase();
    for (int k = 0; k < 256; k++) begin
      feed(sin_at(k), sin_at(k), cos_at(k));
      if (k == 254) begin
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL same_early_vld: got %b expected %b", vld, 1'b0); end
      end
    end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL same_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (i_o !== 16'h0100) begin n_err++; $display("FAIL same_i: got %h expected %h", i_o, 16'h0100); end
    n_vec++; if (q_o !== 16'h0000) begin n_err++; $display("FAIL same_q: got %h expected %h", q_o, 16'h0000); end
    n_vec++; if (mag !== 17'h00100) begin n_err++; $display("FAIL same_mag: got %h expected %h", mag, 17'h00100); end
    accept();
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL same_acc_vld: got %b expected %b", vld, 1'b0); end
    n_vec++; if (i_o !== 16'h0100) begin n_err++; $display("FAIL same_acc_hold: got %h expected %h", i_o, 16'h0100); end
  endtask

  task automatic test_inverted();
    for (int k = 0; k < 256; k++) feed(~cos_at(k), sin_at(k), cos_at(k));
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL inv_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (i_o !== 16'h0000) begin n_err++; $display("FAIL inv_i: got %h expected %h", i_o, 16'h0000); end
    n_vec++; if (q_o !== 16'hFF00) begin n_err++; $display("FAIL inv_q: got %h expected %h", q_o, 16'hFF00); end
    n_vec++; if (mag !== 17'h00100) begin n_err++; $display("FAIL inv_mag: got %h expected %h", mag, 17'h00100); end
    accept();
  endtask

  task automatic test_sparse();
    for (int n = 0; n < 256; n++) begin
      if (n == 255) begin
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL sparse_early_vld: got %b expected %b", vld, 1'b0); end
      end
      repeat (2) @(negedge clk);
      feed(1'b1, 1'b1, 1'b0);
    end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL sparse_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (i_o !== 16'h0100) begin n_err++; $display("FAIL sparse_i: got %h expected %h", i_o, 16'h0100); end
    n_vec++; if (q_o !== 16'hFF00) begin n_err++; $display("FAIL sparse_q: got %h expected %h", q_o, 16'hFF00); end
    n_vec++; if (mag !== 17'h00200) begin n_err++; $display("FAIL sparse_mag: got %h expected %h", mag, 17'h00200); end
    accept();
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    for (int k = 0; k < 256; k++) feed(1'b1, 1'b1, 1'b1);
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_a_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_a_ovf: got %b expected %b", ovf, 1'b0); end
    n_vec++; if (q_o !== 16'h0100) begin n_err++; $display("FAIL bp_a_q: got %h expected %h", q_o, 16'h0100); end
    for (int k = 0; k < 256; k++) begin
      feed(1'b0, 1'b1, 1'b0);
      if (k == 100) begin
        n_vec++; if (i_o !== 16'h0100) begin n_err++; $display("FAIL bp_hold_i: got %h expected %h", i_o, 16'h0100); end
      end
    end
    n_vec++; if (i_o !== 16'hFF00) begin n_err++; $display("FAIL bp_b_i: got %h expected %h", i_o, 16'hFF00); end
    n_vec++; if (q_o !== 16'h0100) begin n_err++; $display("FAIL bp_b_q: got %h expected %h", q_o, 16'h0100); end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_b_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_b_ovf: got %b expected %b", ovf, 1'b1); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_clr_ovf: got %b expected %b", ovf, 1'b0); end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_clr_vld: got %b expected %b", vld, 1'b1); end
    // Acceptance on the exact dump edge.
    for (int k = 0; k < 255; k++) feed(1'b1, 1'b1, 1'b0);
    rdy = 1'b1;
    feed(1'b1, 1'b1, 1'b0);
    rdy = 1'b0;
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_acc_dump_vld: got %b expected %b", vld, 1'b1); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_acc_dump_ovf: got %b expected %b", ovf, 1'b0); end
    n_vec++; if (q_o !== 16'hFF00) begin n_err++; $display("FAIL bp_acc_dump_q: got %h expected %h", q_o, 16'hFF00); end
    // Overrun and clear on the same edge: set wins.
    for (int k = 0; k < 255; k++) feed(1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    feed(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_set_wins_ovf: got %b expected %b", ovf, 1'b1); end
    n_vec++; if (i_o !== 16'h0100) begin n_err++; $display("FAIL bp_set_wins_i: got %h expected %h", i_o, 16'h0100); end
    clr = 1'b1; rdy = 1'b1;
    @(negedge clk);
    clr = 1'b0; rdy = 1'b0;
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL bp_final_vld: got %b expected %b", vld, 1'b0); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_final_ovf: got %b expected %b", ovf, 1'b0); end
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    for (int k = 0; k < 100; k++) feed(1'b1, 1'b1, 1'b1);
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    n_vec++; if (i_o !== 16'h0000) begin n_err++; $display("FAIL rmid_i: got %h expected %h", i_o, 16'h0000); end
    n_vec++; if (q_o !== 16'h0000) begin n_err++; $display("FAIL rmid_q: got %h expected %h", q_o, 16'h0000); end
    n_vec++; if (mag !== 17'h00000) begin n_err++; $display("FAIL rmid_mag: got %h expected %h", mag, 17'h00000); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rmid_vld: got %b expected %b", vld, 1'b0); end
    for (int k = 0; k < 255; k++) feed(1'b1, 1'b0, 1'b1);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rmid_early_vld: got %b expected %b", vld, 1'b0); end
    feed(1'b1, 1'b0, 1'b1);
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL rmid_vld2: got %b expected %b", vld, 1'b1); end
    n_vec++; if (i_o !== 16'hFF00) begin n_err++; $display("FAIL rmid_i2: got %h expected %h", i_o, 16'hFF00); end
    n_vec++; if (q_o !== 16'h0100) begin n_err++; $display("FAIL rmid_q2: got %h expected %h", q_o, 16'h0100); end
    n_vec++; if (mag !== 17'h00200) begin n_err++; $display("FAIL rmid_mag2: got %h expected %h", mag, 17'h00200); end
    accept();
  endtask

  task automatic test_width_corner();
    din = 1'b1; sin_lo = 1'b1; cos_lo = 1'b1; en14 = 1'b1;
    repeat (16383) @(negedge clk);
    n_vec++; if (vld14 !== 1'b0) begin n_err++; $display("FAIL wc_early_vld: got %b expected %b", vld14, 1'b0); end
    @(negedge clk);
    en14 = 1'b0;
    n_vec++; if (vld14 !== 1'b1) begin n_err++; $display("FAIL wc_vld: got %b expected %b", vld14, 1'b1); end
    n_vec++; if (i14 !== 16'h4000) begin n_err++; $display("FAIL wc_i: got %h expected %h", i14, 16'h4000); end
    n_vec++; if (q14 !== 16'h4000) begin n_err++; $display("FAIL wc_q: got %h expected %h", q14, 16'h4000); end
    n_vec++; if (mag14 !== 17'h08000) begin n_err++; $display("FAIL wc_mag: got %h expected %h", mag14, 17'h08000); end
    n_vec++; if (ovf14 !== 1'b0) begin n_err++; $display("FAIL wc_ovf: got %b expected %b", ovf14, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_same_phase();
    test_inverted();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    test_width_corner();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
